// File: rtl/ste_peak_hold.sv
// Peak-hold level follower for an LED bar: holds each new peak, then decays or re-tracks.
// Optional macro STE_PEAK_DECAY_EN enables the stepwise DECAY state; otherwise hold expiry re-tracks the input.
module ste_peak_hold #(
    parameter int DATA_W     = 12,
    parameter int HOLD_LEN   = 64,
    parameter int DECAY_STEP = 8,
    parameter int UPDATE_DIV = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] din_i,
    input  logic              din_valid_i,
    input  logic              clr_i,
    output logic [DATA_W-1:0] dout_o,
    output logic              dout_update_o
);

    localparam int CNT_W = 16;
    localparam logic [CNT_W-1:0] HOLD_RELOAD = CNT_W'(HOLD_LEN - 1);
    localparam logic [CNT_W-1:0] DIV_LAST    = CNT_W'(UPDATE_DIV - 1);

    generate
        if (HOLD_LEN < 1 || HOLD_LEN > 65535) begin : g_bad_hold_len
            $error("HOLD_LEN out of range");
        end
        if (UPDATE_DIV < 1 || UPDATE_DIV > 65535) begin : g_bad_update_div
            $error("UPDATE_DIV out of range");
        end
        if (DECAY_STEP < 1 || DECAY_STEP > (1 << DATA_W) - 1) begin : g_bad_decay_step
            $error("DECAY_STEP out of range");
        end
    endgenerate

`ifdef STE_PEAK_DECAY_EN
    typedef enum logic [1:0] {IDLE, HOLD, DECAY} state_t;
    localparam logic [DATA_W-1:0] DECAY_AMT = DATA_W'(DECAY_STEP);
`else
    typedef enum logic [1:0] {IDLE, HOLD} state_t;
`endif

    state_t            state, state_nxt;
    logic [DATA_W-1:0] peak, peak_nxt;
    logic [CNT_W-1:0]  hold_cnt, hold_nxt;
    logic [CNT_W-1:0]  div_cnt;
    logic              armed;
    logic              accept;
    logic              wrap;

    // armed stays low for the first edge after reset release so that sample is dropped.
    assign accept = din_valid_i && armed && !clr_i;
    assign wrap   = accept && (div_cnt == DIV_LAST);

`ifdef STE_PEAK_DECAY_EN
    logic [DATA_W-1:0] decayed;
    assign decayed = (peak >= DECAY_AMT) ? (peak - DECAY_AMT) : '0;
`endif

    always_comb begin
        // NOTE: defaults first so every path assigns every output and no latch is inferred.
        state_nxt = state;
        peak_nxt  = peak;
        hold_nxt  = hold_cnt;
        if (accept) begin
            if (din_i >= peak && din_i != '0) begin
                state_nxt = HOLD;
                peak_nxt  = din_i;
                hold_nxt  = HOLD_RELOAD;
            end else if (din_i < peak) begin
                case (state)
                    HOLD: begin
                        if (hold_cnt != '0) begin
                            hold_nxt = hold_cnt - CNT_W'(1);
                        end else begin
`ifdef STE_PEAK_DECAY_EN
                            state_nxt = DECAY;
`else
                            peak_nxt = din_i;
                            if (din_i != '0) begin
                                state_nxt = HOLD;
                                hold_nxt  = HOLD_RELOAD;
                            end else begin
                                state_nxt = IDLE;
                                hold_nxt  = '0;
                            end
`endif
                        end
                    end
`ifdef STE_PEAK_DECAY_EN
                    DECAY: begin
                        peak_nxt = (din_i > decayed) ? din_i : decayed;
                        if (peak_nxt == '0) begin
                            state_nxt = IDLE;
                        end
                    end
`endif
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
        if (!rst_n) begin
            state         <= IDLE;
            peak          <= '0;
            hold_cnt      <= '0;
            div_cnt       <= '0;
            dout_o        <= '0;
            dout_update_o <= 1'b0;
            armed         <= 1'b0;
        end else begin
            armed <= 1'b1;
            if (clr_i) begin
                state         <= IDLE;
                peak          <= '0;
                hold_cnt      <= '0;
                div_cnt       <= '0;
                dout_o        <= '0;
                dout_update_o <= 1'b0;
            end else begin
                state         <= state_nxt;
                peak          <= peak_nxt;
                hold_cnt      <= hold_nxt;
                dout_update_o <= wrap;
                if (accept) begin
                    div_cnt <= wrap ? '0 : div_cnt + CNT_W'(1);
                end
                if (wrap) begin
                    dout_o <= peak_nxt;
                end
            end
        end
    end

endmodule
